password_entry_collector: RTL and testbench

- Front-end stage directly upstream of the access-control comparator.
- Gathers four 4-bit keypad/switch digits into one 16-bit code word and presents it with a one-cycle load strobe and a request code.
- Then waits for the comparator's 2-bit status frame before accepting a new entry.
- Tracks digit count and guards the response wait with a timeout.

---
 rtl/password_entry_collector_pkg.sv | 32 +++
 rtl/password_entry_collector_timeout.sv | 33 +++
 rtl/password_entry_collector.sv | 170 +++++++++++++++++
 tb/tb_password_entry_collector.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/password_entry_collector_pkg.sv
// password_entry_collector_pkg: types and constants shared by the entry
// collector and the downstream access-control comparator.
// Contents: FSM state enum, status/request codes, digit and code widths.
package password_entry_collector_pkg;

  localparam int DIGIT_W = 4;
  localparam int CODE_W  = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COLLECT     = 2'd1,
    LOAD        = 2'd2,
    WAIT_STATUS = 2'd3
  } state_t;

  // Comparator status frame; anything other than STAT_NONE is a final result.
  localparam logic [1:0] STAT_NONE  = 2'b00;
  localparam logic [1:0] STAT_DENY  = 2'b01;
  localparam logic [1:0] STAT_GRANT = 2'b10;
  localparam logic [1:0] STAT_LOCK  = 2'b11;

  // Request codes carried alongside the code word.
  localparam logic [1:0] REQ_OPEN   = 2'b00;
  localparam logic [1:0] REQ_ARM    = 2'b01;
  localparam logic [1:0] REQ_CHANGE = 2'b10;
  localparam logic [1:0] REQ_ADMIN  = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/password_entry_collector_timeout.sv
// entry_timeout_counter: free-running cycle counter with synchronous restart
// and a terminal-count indication when the count equals limit-1.
// Ports: clk, rst, clear (restart), enable, limit -> terminal.
module entry_timeout_counter #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Saturates at all-ones instead of wrapping, so a missed terminal count
  // can never alias back into a later one.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + ONE;
    end
  end

  // Deliberately independent of clear: the owner derives clear from its
  // next-state logic, which itself looks at terminal.
  assign terminal = enable && (count == (limit - ONE));

endmodule

// File: rtl/password_entry_collector.sv
// password_entry_collector: collects NUM_DIGITS 4-bit digits into a 16-bit
// code word, strobes it to the comparator with the latched request code, then
// waits for a nonzero status frame or a response timeout before re-arming.
// Ports: clk, rst (sync, active-high); digit_in/digit_enter/clear_req/
// request_sel from the keypad side; status_frame from the comparator;
// data_out/data_load/request_out to the comparator; digit_count, busy and
// timeout_flag as status.
// Optional: define PASSWORD_ENTRY_IDLE_TIMEOUT_EN to discard a partial entry
// after IDLE_TIMEOUT cycles without a digit.
module password_entry_collector
  import password_entry_collector_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int RESP_TIMEOUT = 1000,
  parameter int IDLE_TIMEOUT = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        digit_enter,
  input  logic        clear_req,
  input  logic [1:0]  request_sel,
  input  logic [1:0]  status_frame,
  output logic [15:0] data_out,
  output logic        data_load,
  output logic [1:0]  request_out,
  output logic [2:0]  digit_count,
  output logic        busy,
  output logic        timeout_flag
);

  if ((NUM_DIGITS * DIGIT_W != CODE_W) || (RESP_TIMEOUT < 1) || (IDLE_TIMEOUT < 1)) begin : g_bad_cfg
    $error("password_entry_collector: inconsistent parameters");
  end

`ifdef PASSWORD_ENTRY_IDLE_TIMEOUT_EN
  localparam int CNT_MAX = max_int(RESP_TIMEOUT, IDLE_TIMEOUT);
`else
  localparam int CNT_MAX = RESP_TIMEOUT;
`endif
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] RESP_LIMIT = CNT_W'(RESP_TIMEOUT);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);

  state_t            state, state_nxt;
  logic [CODE_W-1:0] code_q;
  logic [2:0]        cnt_q;
  logic [1:0]        req_q;
  logic              tflag_q;

  logic              shift_en;
  logic              latch_req;
  logic              clr_entry;
  logic              tmo_evt;

  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_tc;
  logic [CNT_W-1:0]  tmr_limit;

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    latch_req = 1'b0;
    clr_entry = 1'b0;
    tmo_evt   = 1'b0;
    case (state)
      IDLE: begin
        // clear_req has nothing to discard here, so a coincident digit is kept.
        if (digit_enter) begin
          shift_en  = 1'b1;
          latch_req = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (clear_req) begin
          clr_entry = 1'b1;
          state_nxt = IDLE;
        end else if (digit_enter) begin
          shift_en = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_nxt = LOAD;
          end
`ifdef PASSWORD_ENTRY_IDLE_TIMEOUT_EN
        end else if (tmr_tc) begin
          clr_entry = 1'b1;
          tmo_evt   = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
      LOAD: begin
        state_nxt = WAIT_STATUS;
      end
      WAIT_STATUS: begin
        // A real status always beats a timeout that lands in the same cycle.
        if (status_frame != STAT_NONE) begin
          clr_entry = 1'b1;
          state_nxt = IDLE;
        end else if (tmr_tc) begin
          clr_entry = 1'b1;
          tmo_evt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        clr_entry = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // The counter restarts on every state change; with the idle timeout it also
  // restarts on each accepted digit while collecting.
`ifdef PASSWORD_ENTRY_IDLE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(IDLE_TIMEOUT);
  assign tmr_clear = (state_nxt != state) || ((state == COLLECT) && digit_enter);
  assign tmr_en    = (state == WAIT_STATUS) || (state == COLLECT);
  assign tmr_limit = (state == WAIT_STATUS) ? RESP_LIMIT : IDLE_LIMIT;
`else
  assign tmr_clear = (state_nxt != state);
  assign tmr_en    = (state == WAIT_STATUS);
  assign tmr_limit = RESP_LIMIT;
`endif

  entry_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .enable   (tmr_en),
    .limit    (tmr_limit),
    .terminal (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      tflag_q <= tmo_evt;
      if (clr_entry) begin
        code_q <= '0;
        cnt_q  <= '0;
        req_q  <= '0;
      end else if (shift_en) begin
        // First digit ends up in the top nibble once the word is complete.
        code_q <= {code_q[CODE_W-DIGIT_W-1:0], digit_in};
        cnt_q  <= cnt_q + 3'd1;
        if (latch_req) begin
          req_q <= request_sel;
        end
      end
    end
  end

  assign data_out     = code_q;
  assign data_load    = (state == LOAD);
  assign busy         = (state == LOAD) || (state == WAIT_STATUS);
  assign digit_count  = cnt_q;
  assign request_out  = req_q;
  assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_password_entry_collector.sv
module tb_password_entry_collector;

  localparam int RT = 8;
  localparam int IT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_in;
  logic        digit_enter;
  logic        clear_req;
  logic [1:0]  request_sel;
  logic [1:0]  status_frame;
  logic [15:0] data_out;
  logic        data_load;
  logic [1:0]  request_out;
  logic [2:0]  digit_count;
  logic        busy;
  logic        timeout_flag;

  always #5 clk = ~clk;

  password_entry_collector #(
    .NUM_DIGITS   (4),
    .RESP_TIMEOUT (RT),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_in     (digit_in),
    .digit_enter  (digit_enter),
    .clear_req    (clear_req),
    .request_sel  (request_sel),
    .status_frame (status_frame),
    .data_out     (data_out),
    .data_load    (data_load),
    .request_out  (request_out),
    .digit_count  (digit_count),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the entry is a list of captured digits; a pending load
  // and a response wait with a plain cycle count.
  logic [3:0] mq[$];
  bit         m_load;
  bit         m_wait;
  int         m_wc;
  int         m_ic;
  logic [1:0] m_req;
  bit         m_flag;

  function automatic logic [15:0] m_code();
    logic [15:0] r;
    r = '0;
    foreach (mq[i]) r = {r[11:0], mq[i]};
    return r;
  endfunction

  task automatic m_clear();
    mq.delete();
    m_wait = 1'b0;
    m_load = 1'b0;
    m_req  = 2'b00;
  endtask

  task automatic model_step();
    m_flag = 1'b0;
    if (rst) begin
      m_clear();
    end else if (m_load) begin
      m_load = 1'b0;
      m_wait = 1'b1;
      m_wc   = 0;
    end else if (m_wait) begin
      if (status_frame != 2'b00) begin
        m_clear();
      end else if (m_wc == RT - 1) begin
        m_clear();
        m_flag = 1'b1;
      end else begin
        m_wc++;
      end
    end else if (clear_req && mq.size() > 0) begin
      m_clear();
    end else if (digit_enter) begin
      if (mq.size() == 0) m_req = request_sel;
      mq.push_back(digit_in);
      m_ic = 0;
      if (mq.size() == 4) m_load = 1'b1;
`ifdef PASSWORD_ENTRY_IDLE_TIMEOUT_EN
    end else if (mq.size() > 0) begin
      if (m_ic == IT - 1) begin
        m_clear();
        m_flag = 1'b1;
      end else begin
        m_ic++;
      end
`endif
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    digit_enter  = 1'b0;
    clear_req    = 1'b0;
    status_frame = 2'b00;
    rst          = 1'b0;
  endtask

  task automatic enter_digit(input logic [3:0] d, input logic [1:0] sel);
    digit_in    = d;
    request_sel = sel;
    digit_enter = 1'b1;
    tick();
    digit_enter = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_model(input int cyc);
    tests++;
    if (data_out !== m_code() || data_load !== m_load || busy !== (m_load | m_wait) ||
        digit_count !== 3'(mq.size()) || request_out !== m_req || timeout_flag !== m_flag) begin
      fails++;
      $display("FAIL random cycle %0d: got data=%h load=%b busy=%b cnt=%0d req=%0d tmo=%b expected data=%h load=%b busy=%b cnt=%0d req=%0d tmo=%b",
               cyc, data_out, data_load, busy, digit_count, request_out, timeout_flag,
               m_code(), m_load, m_load | m_wait, mq.size(), m_req, m_flag);
    end
  endtask

  typedef struct {
    logic        r;
    logic        de;
    logic [3:0]  d;
    logic        cl;
    logic [1:0]  sel;
    logic [1:0]  st;
    logic [15:0] e_data;
    logic        e_load;
    logic [2:0]  e_cnt;
    logic        e_busy;
    logic [1:0]  e_req;
    logic        e_flag;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic de, input logic [3:0] d, input logic cl,
                     input logic [1:0] sel, input logic [1:0] st, input logic [15:0] e_data,
                     input logic e_load, input logic [2:0] e_cnt, input logic e_busy,
                     input logic [1:0] e_req, input logic e_flag);
    vec_t v;
    v.r = r; v.de = de; v.d = d; v.cl = cl; v.sel = sel; v.st = st;
    v.e_data = e_data; v.e_load = e_load; v.e_cnt = e_cnt;
    v.e_busy = e_busy; v.e_req = e_req; v.e_flag = e_flag;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; digit_in = '0; digit_enter = 1'b0; clear_req = 1'b0;
    request_sel = '0; status_frame = '0;

    //   r de d    cl sel st     data     ld cnt bsy req tmo
    add(1, 0, 4'h0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);   // reset state
    add(0, 1, 4'h1, 0, 1, 0, 16'h0001, 0, 1, 0, 1, 0);
    add(0, 1, 4'h2, 0, 2, 0, 16'h0012, 0, 2, 0, 1, 0);   // sel ignored after 1st
    add(0, 1, 4'h3, 0, 1, 0, 16'h0123, 0, 3, 0, 1, 0);
    add(0, 1, 4'h4, 0, 1, 0, 16'h1234, 1, 4, 1, 1, 0);   // LOAD
    add(0, 0, 4'h0, 0, 1, 0, 16'h1234, 0, 4, 1, 1, 0);
    add(0, 0, 4'h0, 0, 1, 0, 16'h1234, 0, 4, 1, 1, 0);
    add(0, 0, 4'h0, 0, 1, 2, 16'h0000, 0, 0, 0, 0, 0);   // grant
    add(0, 1, 4'hA, 0, 2, 0, 16'h000A, 0, 1, 0, 2, 0);
    add(0, 1, 4'hB, 0, 2, 0, 16'h00AB, 0, 2, 0, 2, 0);
    add(0, 0, 4'h0, 1, 2, 0, 16'h0000, 0, 0, 0, 0, 0);   // clear partial
    add(0, 1, 4'h5, 0, 3, 0, 16'h0005, 0, 1, 0, 3, 0);
    add(0, 1, 4'h6, 0, 3, 0, 16'h0056, 0, 2, 0, 3, 0);
    add(0, 1, 4'h7, 0, 3, 0, 16'h0567, 0, 3, 0, 3, 0);
    add(0, 1, 4'h8, 0, 3, 0, 16'h5678, 1, 4, 1, 3, 0);
    add(0, 1, 4'h9, 1, 0, 0, 16'h5678, 0, 4, 1, 3, 0);   // ignored in WAIT
    add(0, 1, 4'h9, 1, 0, 0, 16'h5678, 0, 4, 1, 3, 0);
    add(0, 0, 4'h0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0);   // deny
    add(0, 1, 4'h3, 0, 0, 0, 16'h0003, 0, 1, 0, 0, 0);
    add(0, 1, 4'h9, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0);   // clear beats digit
    add(0, 1, 4'h7, 1, 1, 0, 16'h0007, 0, 1, 0, 1, 0);   // clear ignored in IDLE
    add(0, 0, 4'h0, 1, 1, 0, 16'h0000, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].r; digit_enter = tbl[i].de; digit_in = tbl[i].d;
      clear_req = tbl[i].cl; request_sel = tbl[i].sel; status_frame = tbl[i].st;
      tick();
      tests++;
      if (data_out !== tbl[i].e_data || data_load !== tbl[i].e_load ||
          digit_count !== tbl[i].e_cnt || busy !== tbl[i].e_busy ||
          request_out !== tbl[i].e_req || timeout_flag !== tbl[i].e_flag) begin
        fails++;
        $display("FAIL vector %0d: got data=%h load=%b cnt=%0d busy=%b req=%0d tmo=%b expected data=%h load=%b cnt=%0d busy=%b req=%0d tmo=%b",
                 i, data_out, data_load, digit_count, busy, request_out, timeout_flag,
                 tbl[i].e_data, tbl[i].e_load, tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_req, tbl[i].e_flag);
      end
    end
    idle_inputs();

    // Response timeout lands exactly RT cycles after entering WAIT_STATUS.
    enter_digit(4'h1, 2'd2); enter_digit(4'h1, 2'd2);
    enter_digit(4'h1, 2'd2); enter_digit(4'h1, 2'd2);
    chk("timeout_load", {31'b0, data_load}, 32'd1);
    tick();
    chk("timeout_wait_entry", {30'b0, busy, timeout_flag}, 32'b10);
    for (int k = 1; k <= RT; k++) begin
      tick();
      chk($sformatf("timeout_k%0d", k), {30'b0, timeout_flag, busy},
          (k == RT) ? 32'b10 : 32'b01);
    end
    tick();
    chk("timeout_after", {29'b0, timeout_flag, data_load, busy}, 32'b0);

    // Status arriving in the timeout cycle wins.
    enter_digit(4'h2, 2'd0); enter_digit(4'h2, 2'd0);
    enter_digit(4'h2, 2'd0); enter_digit(4'h2, 2'd0);
    tick();
    for (int k = 1; k < RT; k++) tick();
    status_frame = 2'b11;
    tick();
    status_frame = 2'b00;
    chk("status_beats_timeout", {29'b0, timeout_flag, busy, 1'b0}, 32'b0);
    chk("status_beats_timeout_cnt", {29'b0, digit_count}, 32'd0);

    // Reset after three digits, then a fresh entry.
    enter_digit(4'h7, 2'd1); enter_digit(4'h7, 2'd1); enter_digit(4'h7, 2'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_entry", {data_out, 13'b0, digit_count}, 32'd0);
    enter_digit(4'hF, 2'd1); enter_digit(4'h0, 2'd1);
    enter_digit(4'h0, 2'd1); enter_digit(4'h1, 2'd1);
    chk("rst_new_entry", {data_out, 15'b0, data_load}, {16'hF001, 16'h0001});

    // Reset during the response wait.
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_wait", {16'b0, data_out}, 32'd0);
    chk("rst_mid_wait_ctl", {29'b0, busy, data_load, timeout_flag}, 32'd0);

`ifdef PASSWORD_ENTRY_IDLE_TIMEOUT_EN
    enter_digit(4'h3, 2'd1); enter_digit(4'h4, 2'd1);
    for (int k = 1; k < IT; k++) tick();
    chk("idle_before", {28'b0, timeout_flag, digit_count}, 32'd2);
    tick();
    chk("idle_expire", {28'b0, timeout_flag, digit_count}, 32'b1000);
`endif

    // Randomised traffic against the reference model.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      digit_enter  = ($urandom_range(0, 2) == 0);
      digit_in     = 4'($urandom_range(0, 15));
      clear_req    = ($urandom_range(0, 11) == 0);
      request_sel  = 2'($urandom_range(0, 3));
      status_frame = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick();
      chk_model(c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
